// File: rtl/riscv_enc_pkg.sv
// Shared encodings for the RISC-V instruction assembler: format and error
// codes plus the opcodes the packer treats specially.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FmtI = 3'd0,
        FmtS = 3'd1,
        FmtB = 3'd2,
        FmtU = 3'd3,
        FmtJ = 3'd4,
        FmtR = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ErrNone  = 2'd0,
        ErrRange = 2'd1,
        ErrAlign = 2'd2,
        ErrFmt   = 2'd3
    } err_e;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [2:0] F3_SLTIU   = 3'b011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields plus a byte-offset immediate in,
// RV32 instruction word out, with range/alignment checking of the immediate.
module instr_pack
    import riscv_enc_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [2:0]   fmt_i,
    input  logic [6:0]   opcode_i,
    input  logic [4:0]   rd_i,
    input  logic [4:0]   rs1_i,
    input  logic [4:0]   rs2_i,
    input  logic [2:0]   funct3_i,
    input  logic [6:0]   funct7_i,
    input  logic [N-1:0] imm_i,
    output logic [N-1:0] word_o,
    output logic         err_o,
    output logic [1:0]   err_code_o
);

    localparam logic signed [N-1:0] Imm12Min = -(N'(2048));
    localparam logic signed [N-1:0] Imm12Max = N'(2047);
    localparam logic signed [N-1:0] ImmBMin  = -(N'(4096));
    localparam logic signed [N-1:0] ImmBMax  = N'(4094);
    localparam logic signed [N-1:0] ImmJMin  = -(N'(1 << 20));
    localparam logic signed [N-1:0] ImmJMax  = N'((1 << 20) - 2);

    logic signed [N-1:0] imm_s;
    logic                sltiu;
    logic                range_err;
    logic                align_err;
    logic                bad_fmt;

    assign imm_s = $signed(imm_i);
    // SLTIU compares unsigned, so its immediate is range-checked as 0..4095
    assign sltiu = (opcode_i == OPC_OPIMM) && (funct3_i == F3_SLTIU);

    // Per-format range/alignment check and bit scatter
    always_comb begin
        word_o    = '0;
        range_err = 1'b0;
        align_err = 1'b0;
        bad_fmt   = 1'b0;
        case (fmt_i)
            FmtI: begin
                if (sltiu) range_err = (imm_i[N-1:12] != '0);
                else       range_err = (imm_s < Imm12Min) || (imm_s > Imm12Max);
                word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            FmtS: begin
                range_err = (imm_s < Imm12Min) || (imm_s > Imm12Max);
                word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            end
            FmtB: begin
                range_err = (imm_s < ImmBMin) || (imm_s > ImmBMax);
                align_err = imm_i[0];
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
            end
            FmtU: begin
                align_err = (imm_i[11:0] != '0);
                word_o = {imm_i[31:12], rd_i, opcode_i};
            end
            FmtJ: begin
                range_err = (imm_s < ImmJMin) || (imm_s > ImmJMax);
                align_err = imm_i[0];
                word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            end
            FmtR: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            default: bad_fmt = 1'b1;
        endcase
    end

    // Range outranks misalignment when both apply
    always_comb begin
        err_o      = bad_fmt || range_err || align_err;
        err_code_o = ErrNone;
        if (bad_fmt)        err_code_o = ErrFmt;
        else if (range_err) err_code_o = ErrRange;
        else if (align_err) err_code_o = ErrAlign;
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction assembler: packs accepted field bundles and writes
// them to IMEM at an auto-incrementing word address through a one-entry
// output register. Rejected bundles are consumed and flagged by err_valid.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [N-1:0]      in_imm,
    output logic              imem_we,
    output logic [AWIDTH-1:0] imem_addr,
    output logic [N-1:0]      imem_din,
    input  logic              imem_ready,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [AWIDTH:0]   count
);

    logic [N-1:0]      pack_word;
    logic              pack_err;
    logic [1:0]        pack_code;

    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [N-1:0]      din_q, din_d;
    logic              err_valid_q, err_valid_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [AWIDTH:0]   count_q, count_d;

    logic              fire;
    logic              done;

    instr_pack #(
        .N (N)
    ) u_pack (
        .fmt_i      (in_fmt),
        .opcode_i   (in_opcode),
        .rd_i       (in_rd),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .funct3_i   (in_funct3),
        .funct7_i   (in_funct7),
        .imm_i      (in_imm),
        .word_o     (pack_word),
        .err_o      (pack_err),
        .err_code_o (pack_code)
    );

    // The output slot frees up in the same cycle its write completes
    assign in_ready = (!we_q || imem_ready) && !start;
    assign fire     = in_valid && in_ready;
    assign done     = we_q && imem_ready;

    // Next state: start overrides, else retire the pending write, then load
    always_comb begin
        we_d        = we_q && !imem_ready;
        addr_d      = addr_q;
        din_d       = din_q;
        count_d     = count_q;
        err_valid_d = 1'b0;
        err_code_d  = ErrNone;
        if (start) begin
            we_d    = 1'b0;
            addr_d  = start_addr;
            count_d = '0;
        end else begin
            if (done) begin
                addr_d = addr_q + AWIDTH'(1);
                if (count_q != '1) count_d = count_q + (AWIDTH + 1)'(1);
            end
            if (fire) begin
                if (pack_err) begin
                    err_valid_d = 1'b1;
                    err_code_d  = pack_code;
                end else begin
                    we_d  = 1'b1;
                    din_d = pack_word;
                end
            end
        end
    end

    // State registers; reset discards any pending word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            count_q     <= '0;
        end else begin
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            count_q     <= count_d;
        end
    end

    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_din  = din_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes and error codes are
// queued when a bundle is accepted and checked when the DUT emits them.
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam int unsigned N      = 32;
    localparam int unsigned AWIDTH = 14;

    localparam int KWrite = 0;
    localparam int KErr   = 1;
    localparam int KNone  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [AWIDTH-1:0] start_addr;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [N-1:0]      in_imm;
    logic              imem_we;
    logic [AWIDTH-1:0] imem_addr;
    logic [N-1:0]      imem_din;
    logic              imem_ready;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [AWIDTH:0]   count;

    int vectors     = 0;
    int miscompares = 0;
    int n_done      = 0;
    int count_base  = 0;

    logic [AWIDTH-1:0]          exp_addr;
    logic [AWIDTH+N-1:0]        wr_q[$];
    logic [1:0]                 err_q[$];

    instr_encoder #(
        .N      (N),
        .AWIDTH (AWIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_din   (imem_din),
        .imem_ready (imem_ready),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All tasks are entered and left just after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [AWIDTH-1:0] a);
        start      = 1'b1;
        start_addr = a;
        #1;
        check("in_ready_during_start", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        start      = 1'b0;
        exp_addr   = a;
        count_base = n_done;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input int kind,
                        input logic [31:0] exp);
        bit ok = 1'b0;
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (kind == KWrite) begin
                    wr_q.push_back({exp_addr, exp});
                    exp_addr = exp_addr + AWIDTH'(1);
                end else if (kind == KErr) begin
                    err_q.push_back(exp[1:0]);
                end
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
        check({tag, "_count"}, 32'(count), 32'(n_done - count_base));
    endtask

    // Scoreboard side: retire completed writes and error pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we && imem_ready) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", imem_din, 32'hxxxxxxxx);
                end else begin
                    logic [AWIDTH+N-1:0] e;
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e[AWIDTH+N-1:N]));
                    check("wr_din", imem_din, e[N-1:0]);
                end
                n_done++;
            end
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    check("unexpected_err", 32'(err_code), 32'hxxxxxxxx);
                end else begin
                    logic [1:0] ec;
                    ec = err_q.pop_front();
                    check("err_code", 32'(err_code), 32'(ec));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got 0x00000001, expected 0x00000000");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; in_valid = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0; imem_ready = 1'b1;
        exp_addr = '0;
        #3;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_din", imem_din, 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        idle(2);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Basic packing
        do_start('0);
        send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFF, KWrite, 32'hFFF00093);
        idle(2);
        check("count_one", 32'(count), 32'd1);
        send(3'd1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'd8, KWrite, 32'h0021A423);
        send(3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, KWrite,
             32'h123452B7);
        send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b011, 7'd0, 32'd4095, KWrite, 32'hFFF03093);
        idle(2);
        check_quiet("after_basic");

        // Rejections: range, misalignment, precedence, bad format
        send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b011, 7'd0, 32'hFFFFFFFF, KErr, 32'd1);
        send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, KErr, 32'd1);
        send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF7FF, KErr, 32'd1);
        send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, KErr, 32'd2);
        send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096, KErr, 32'd1);
        send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4095, KErr, 32'd1);
        send(3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001, KErr, 32'd2);
        send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00100000, KErr, 32'd1);
        send(3'd1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'd2048, KErr, 32'd1);
        send(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, KErr, 32'd3);
        send(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, KErr, 32'd3);
        idle(2);
        check_quiet("after_errors");

        // Legal boundaries and remaining formats, back to back
        send(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFFC, KWrite, 32'hFE208EE3);
        send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000800, KWrite, 32'h001000EF);
        send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h000FFFFE, KWrite, 32'h7FFFF0EF);
        send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFF00000, KWrite, 32'h800000EF);
        send(3'd5, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEADBEEF, KWrite, 32'h002081B3);
        send(3'd5, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0, KWrite, 32'h402081B3);
        send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF800, KWrite, 32'h80000093);
        send(3'd1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'hFFFFFFFC, KWrite, 32'hFE21AE23);
        idle(2);
        check_quiet("after_legal");

        // Backpressure: second bundle waits while the first is held
        imem_ready = 1'b0;
        send(3'd0, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, KWrite, 32'h00500113);
        fork
            send(3'd0, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd6, KWrite, 32'h00600193);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_din_held", imem_din, 32'h00500113);
                end
                @(posedge clk);
                #1;
                imem_ready = 1'b1;
            end
        join
        idle(3);
        check_quiet("after_stall");

        // Address wrap at the top of IMEM
        do_start(14'h3FFF);
        send(3'd0, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, KWrite, 32'h00100213);
        send(3'd0, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, KWrite, 32'h00200293);
        idle(2);
        check_quiet("after_wrap");

        // start drops a pending word
        imem_ready = 1'b0;
        send(3'd0, 7'b0010011, 5'd6, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7, KNone, 32'd0);
        check("pending_we", 32'(imem_we), 32'd1);
        do_start(14'h0100);
        check_quiet("after_start_drop");
        imem_ready = 1'b1;
        send(3'd0, 7'b0010011, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, KWrite, 32'h00800393);
        idle(2);
        check_quiet("after_restart");

        // Reset mid-write clears everything at once
        imem_ready = 1'b0;
        send(3'd0, 7'b0010011, 5'd8, 5'd0, 5'd0, 3'b000, 7'd0, 32'd9, KNone, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(imem_we), 32'd0);
        check("midrst_addr", 32'(imem_addr), 32'd0);
        check("midrst_din", imem_din, 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_err", 32'(err_valid), 32'd0);
        idle(2);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        exp_addr = '0;
        count_base = n_done;
        #1;
        check("ready_after_midrst", 32'(in_ready), 32'd1);
        send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFF, KWrite, 32'hFFF00093);
        idle(3);
        check_quiet("after_midrst");

        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("err_queue_drained", 32'(err_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V instruction assembler: accepts decoded fields (format, opcode, registers, funct, full-width immediate) and packs them into a 32-bit instruction word.
- It is the inverse of the core's immediate extraction. Each immediate is range- and alignment-checked against the field it must fit.
- Accepted words are written sequentially into instruction memory through an auto-incrementing write port. Used by the on-chip loader/self-test path to build programs in IMEM.

Parameters:
- N, 32, instruction/immediate width.
- AWIDTH, 14, IMEM word-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load write address from start_addr; clear count
- start_addr  in  AWIDTH  first IMEM word address
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- in_fmt  in  3  0=I 1=S 2=B 3=U 4=J 5=R; 6,7 illegal
- in_opcode  in  7  opcode
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3
- in_funct7  in  7  (R only)
- in_imm  in  N  immediate value, byte-offset semantics (U: full value, low 12 bits zero)
- imem_we  out  1  write strobe
- imem_addr  out  AWIDTH  word address
- imem_din  out  N  packed instruction
- imem_ready  in  1  IMEM accepts the write this cycle
- err_valid  out  1  one-cycle pulse, rejected bundle
- err_code  out  2  1=range 2=misaligned 3=bad fmt
- count  out  AWIDTH+1  words written since last start

Behaviour:
- Reset (async, rst_n=0): imem_we=0, imem_addr=0, imem_din=0, err_valid=0, err_code=0, count=0. in_ready=1 once reset is released.
- Output register: one entry. in_ready = !imem_we || imem_ready, and is forced to 0 in any cycle where start=1.
- Latency: an accepted legal bundle appears on imem_we/imem_din the next cycle.
- Write completion: a write completes on a cycle with imem_we && imem_ready. On completion, imem_addr increments, wrapping modulo 2^AWIDTH, and count increments, saturating at all-ones.
- Hold rule: while imem_we=1 and imem_ready=0, imem_addr and imem_din are held stable.
- Range and alignment checks, in_imm treated as signed N-bit:
  - I: -2048..2047.
  - SLTIU exception (opcode 0010011, funct3 011): unsigned 0..4095, packed zero-extended.
  - S: -2048..2047.
  - B: -4096..4094; bit0 set -> misaligned.
  - U: low 12 bits nonzero -> misaligned; all 32-bit values otherwise legal.
  - J: -2^20..2^20-2; bit0 set -> misaligned.
  - R: in_imm ignored.
- Precedence: if both range and misaligned apply, report range.
- Rejected bundle: it is still consumed (handshake completes). No write is issued, imem_addr and count are unchanged, and err_valid pulses the next cycle with err_code.
- Bad fmt (6, 7): err_code=3.
- Packing: standard RV32 layouts. rd is unused for S/B and rs1/rs2 unused where the format lacks them; those bit positions are driven from imm or zero per format.
- start: takes priority over everything. It clears imem_we (a pending word is dropped), loads imem_addr=start_addr, clears count, and suppresses err_valid that cycle.
- Reset mid-write: the pending word is lost; no partial state survives.

Decomposition:
- Package riscv_enc_pkg holds:
  - fmt codes;
  - err codes;
  - OPC_OPIMM=0010011, F3_SLTIU=011, OPC_LUI, OPC_STORE, OPC_BRANCH, OPC_JAL.
- Sub-module instr_pack: purely combinational fields+imm -> {word, err, err_code}.
- instr_encoder wraps instr_pack with the handshake, output register, address counter and error pulse.

Test Plan:
- start, start_addr=0. Send I, opcode 0010011, f3 000, rd=1, rs1=0, imm=0xFFFFFFFF (addi x1,x0,-1) -> imem_din=0xFFF00093 at addr 0, count=1.
- S, opcode 0100011, f3 010, rs1=3, rs2=2, imm=8 -> 0x0021A423 at addr 1. U, rd=5, opcode 0110111, imm=0x12345000 -> 0x123452B7 at addr 2.
- SLTIU rd=1, rs1=0, imm=4095 -> 0xFFF03093. SLTIU imm=0xFFFFFFFF -> err_code=1. ADDI imm=2048 -> err_code=1. In all error cases imem_addr is unchanged and no imem_we.
- B, imm=3 -> err_code=2. U, imm=0x12345001 -> err_code=2. fmt=7 -> err_code=3. count stays the same throughout.
- imem_ready=0 for 3 cycles with 2 bundles pending -> in_ready=0 after the first is accepted; imem_din held; words land in order at consecutive addresses.
- start_addr=2^AWIDTH-1, two writes -> addresses 0x3FFF then 0x0000. start asserted while imem_we=1 -> pending word dropped. rst_n pulsed mid-stream -> all outputs 0 immediately.
